pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined add/subtract unit. It splits a W-bit operation into STAGES equal slices and registers the carry between slices. It provides carry, signed-overflow and zero flags and a valid/ready handshake with back-pressure. It feeds the execute stage and multi-cycle M-extension datapaths wherever a full-width single-cycle carry chain limits timing.

Parameters:
W, 32, operand/result width in bits; must satisfy W % STAGES == 0
STAGES, 2, number of pipeline register stages (1..W); slice width S = W/STAGES

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  unit can accept operands this cycle
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in (add mode) / borrow-in (sub mode)
in_sub  input  1  0 = A+B+cin, 1 = A-B-borrow
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
adder_result  output  W  sum/difference, modulo 2^W
out_cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
out_ovf  output  1  signed two's-complement overflow
out_zero  output  1  adder_result == 0

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, data, carry and flag registers clear to 0. adder_result=0, out_valid=0, out_cout=0, out_ovf=0, out_zero=0. in_ready follows the rule below, so it is 1 during reset.
- Effective operands: b_eff = in_sub ? ~in_b : in_b; c_eff = in_sub ? ~in_cin : in_cin.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=1, every stage shifts forward one position.
  - Stage 0 captures in_valid as its valid bit. Bubbles (valid=0) propagate like data.
  - When adv=0, every register holds. adder_result and all flags stay stable while out_valid=1 and out_ready=0.
- Accept: a transfer occurs when in_valid && in_ready. Operands are ignored when in_valid=0.
- Slice k (k = 0..STAGES-1) covers bits [k*S+S-1 : k*S].
  - Pipeline stage k computes slice k using the A/B_eff bits carried forward in skew registers and the carry registered by stage k-1. Stage 0 uses c_eff.
  - Already-computed lower result slices travel forward with the operation.
  - Each stage computes its slice with a slice-local carry-lookahead / "+" expression.
- Latency: an operand accepted in cycle t produces out_valid=1 after rising edge t+STAGES-1 (i.e. STAGES register stages, first stage registers at the accept edge), assuming no stall. Throughput: 1 operation/cycle when out_ready=1.
- Flags are computed in the final stage and registered with the result:
  - out_cout = carry out of bit W-1.
  - out_ovf = (a[W-1]==b_eff[W-1]) && (result[W-1]!=a[W-1]).
  - out_zero = (result == 0).
- Wrap-around: the result is always modulo 2^W. No saturation.
- Simultaneous events:
  - Output drain and input accept in the same cycle are legal and must not drop or duplicate data.
  - out_ready=0 while pipeline bubbles exist still blocks the whole pipe. There is no bubble collapsing; this is intentional for simplicity.
- Reset mid-operation: all in-flight operations are discarded. No partial results appear after reset release.
- STAGES=1: degenerates to one registered full-width adder, with the same handshake.
- Elaboration check: W % STAGES != 0 or STAGES < 1 or STAGES > W is a fatal error.

Test Plan:
- W=32, STAGES=2, add: A=0xFFFF_FFFF, B=0x0000_0001, cin=0 -> after 2 cycles result=0x0000_0000, cout=1, zero=1, ovf=0. This exercises the carry crossing the slice boundary.
- Sub: A=0x8000_0000, B=0x0000_0001, sub=1, cin=0 -> result=0x7FFF_FFFF, ovf=1, cout=1; then A=5, B=7 -> result=0xFFFF_FFFE, cout=0, ovf=0.
- Back-to-back stream: 8 random operations with out_ready=1 -> 8 results on consecutive cycles, in order, matching the reference model A±B±c.
- Stall: hold out_ready=0 for 3 cycles with the pipe full -> in_ready=0, adder_result and flags constant, no loss. On release, results resume in order.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 operations in flight -> outputs 0 immediately, no stale out_valid after release.
- Parameter sweep: STAGES ∈ {1,4,8} with W=32, plus W=8 with STAGES=8, running random add/sub -> latency equals STAGES and results match the model.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The slave modport is the adder's view; master is the producer/consumer side.
interface pipelined_cla_adder_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] adder_result;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, adder_result, out_cout, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, adder_result, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Add/subtract unit split into STAGES slices of W/STAGES bits, carry registered
// between slices; the whole pipe advances together under output back-pressure.
module pipelined_cla_adder #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);

  if (STAGES < 1 || STAGES > W || (W % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_cla_adder: W must be a multiple of STAGES and 1 <= STAGES <= W");
  end

  localparam int NS = (STAGES < 1) ? 1 : STAGES;
  localparam int S  = W / NS;
  localparam int L  = NS - 1;

  logic         w_adv;
  logic [W-1:0] w_b_eff;
  logic         w_c_eff;
  logic         w_ovf_nxt;
  logic         w_zero_nxt;

  logic [NS-1:0] w_vld_in;
  logic [NS-1:0] w_cy_in;
  logic [NS-1:0] w_cy_nxt;
  logic [W-1:0]  w_a_in   [NS];
  logic [W-1:0]  w_b_in   [NS];
  logic [W-1:0]  w_res_in [NS];
  logic [W-1:0]  w_res_nxt[NS];

  logic [NS-1:0] r_vld;
  logic [NS-1:0] r_cy;
  logic [W-1:0]  r_a  [NS];
  logic [W-1:0]  r_b  [NS];
  logic [W-1:0]  r_res[NS];
  logic          r_ovf;
  logic          r_zero;

  // Subtraction is A + ~B + ~borrow, so the slices only ever add.
  assign w_b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign w_c_eff = bus.in_sub ? ~bus.in_cin : bus.in_cin;

  assign w_adv        = !r_vld[L] || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam logic [W-1:0] SLICE_MASK = ({W{1'b1}} >> (W - S)) << (k * S);
    logic [S:0] w_sum;

    if (k == 0) begin : g_first
      assign w_vld_in[k] = bus.in_valid;
      assign w_a_in[k]   = bus.in_a;
      assign w_b_in[k]   = w_b_eff;
      assign w_cy_in[k]  = w_c_eff;
      assign w_res_in[k] = '0;
    end else begin : g_next
      assign w_vld_in[k] = r_vld[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_cy_in[k]  = r_cy[k-1];
      assign w_res_in[k] = r_res[k-1];
    end

    assign w_sum = {1'b0, w_a_in[k][k*S +: S]} + {1'b0, w_b_in[k][k*S +: S]}
                 + {{S{1'b0}}, w_cy_in[k]};
    assign w_cy_nxt[k]  = w_sum[S];
    assign w_res_nxt[k] = (w_res_in[k] & ~SLICE_MASK) | (W'(w_sum[S-1:0]) << (k * S));
  end

  assign w_ovf_nxt  = (w_a_in[L][W-1] == w_b_in[L][W-1]) &&
                      (w_res_nxt[L][W-1] != w_a_in[L][W-1]);
  assign w_zero_nxt = (w_res_nxt[L] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_cy   <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < NS; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_cy[k]  <= w_cy_nxt[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_res[k] <= w_res_nxt[k];
      end
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign bus.out_valid    = r_vld[L];
  assign bus.adder_result = r_res[L];
  assign bus.out_cout     = r_cy[L];
  assign bus.out_ovf      = r_ovf;
  assign bus.out_zero     = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench: main 32-bit/2-stage unit plus shadow instances (other STAGES, W=8) fed
// the same operands, all checked every cycle against an arithmetic model.
module tb_pipelined_cla_adder;

  localparam int NCH = 5;
  localparam int CW [NCH] = '{32, 32, 32, 32, 8};
  localparam int CS [NCH] = '{2, 1, 4, 8, 8};

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
    int          stl;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.W(32)) m_if ();
  pipelined_cla_adder_if #(.W(32)) s1_if ();
  pipelined_cla_adder_if #(.W(32)) s4_if ();
  pipelined_cla_adder_if #(.W(32)) s8_if ();
  pipelined_cla_adder_if #(.W(8))  n8_if ();

  pipelined_cla_adder #(.W(32), .STAGES(2)) dut    (.clk(clk), .rst_n(rst_n), .bus(m_if));
  pipelined_cla_adder #(.W(32), .STAGES(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(s1_if));
  pipelined_cla_adder #(.W(32), .STAGES(4)) dut_s4 (.clk(clk), .rst_n(rst_n), .bus(s4_if));
  pipelined_cla_adder #(.W(32), .STAGES(8)) dut_s8 (.clk(clk), .rst_n(rst_n), .bus(s8_if));
  pipelined_cla_adder #(.W(8),  .STAGES(8)) dut_n8 (.clk(clk), .rst_n(rst_n), .bus(n8_if));

  // Shadow units see every operand the bench presents and never stall.
  assign s1_if.in_valid = m_if.in_valid;  assign s1_if.in_a = m_if.in_a;
  assign s1_if.in_b = m_if.in_b;  assign s1_if.in_cin = m_if.in_cin;
  assign s1_if.in_sub = m_if.in_sub;  assign s1_if.out_ready = 1'b1;
  assign s4_if.in_valid = m_if.in_valid;  assign s4_if.in_a = m_if.in_a;
  assign s4_if.in_b = m_if.in_b;  assign s4_if.in_cin = m_if.in_cin;
  assign s4_if.in_sub = m_if.in_sub;  assign s4_if.out_ready = 1'b1;
  assign s8_if.in_valid = m_if.in_valid;  assign s8_if.in_a = m_if.in_a;
  assign s8_if.in_b = m_if.in_b;  assign s8_if.in_cin = m_if.in_cin;
  assign s8_if.in_sub = m_if.in_sub;  assign s8_if.out_ready = 1'b1;
  assign n8_if.in_valid = m_if.in_valid;  assign n8_if.in_a = m_if.in_a[7:0];
  assign n8_if.in_b = m_if.in_b[7:0];  assign n8_if.in_cin = m_if.in_cin;
  assign n8_if.in_sub = m_if.in_sub;  assign n8_if.out_ready = 1'b1;

  logic        c_vld [NCH];
  logic        c_ird [NCH];
  logic        c_ord [NCH];
  logic        c_cout[NCH];
  logic        c_ovf [NCH];
  logic        c_zero[NCH];
  logic [31:0] c_res [NCH];

  assign c_vld[0] = m_if.out_valid;   assign c_ird[0] = m_if.in_ready;   assign c_ord[0] = m_if.out_ready;
  assign c_vld[1] = s1_if.out_valid;  assign c_ird[1] = s1_if.in_ready;  assign c_ord[1] = s1_if.out_ready;
  assign c_vld[2] = s4_if.out_valid;  assign c_ird[2] = s4_if.in_ready;  assign c_ord[2] = s4_if.out_ready;
  assign c_vld[3] = s8_if.out_valid;  assign c_ird[3] = s8_if.in_ready;  assign c_ord[3] = s8_if.out_ready;
  assign c_vld[4] = n8_if.out_valid;  assign c_ird[4] = n8_if.in_ready;  assign c_ord[4] = n8_if.out_ready;
  assign c_res[0] = m_if.adder_result;   assign c_cout[0] = m_if.out_cout;
  assign c_res[1] = s1_if.adder_result;  assign c_cout[1] = s1_if.out_cout;
  assign c_res[2] = s4_if.adder_result;  assign c_cout[2] = s4_if.out_cout;
  assign c_res[3] = s8_if.adder_result;  assign c_cout[3] = s8_if.out_cout;
  assign c_res[4] = {24'h0, n8_if.adder_result};  assign c_cout[4] = n8_if.out_cout;
  assign c_ovf[0] = m_if.out_ovf;   assign c_zero[0] = m_if.out_zero;
  assign c_ovf[1] = s1_if.out_ovf;  assign c_zero[1] = s1_if.out_zero;
  assign c_ovf[2] = s4_if.out_ovf;  assign c_zero[2] = s4_if.out_zero;
  assign c_ovf[3] = s8_if.out_ovf;  assign c_zero[3] = s8_if.out_zero;
  assign c_ovf[4] = n8_if.out_ovf;  assign c_zero[4] = n8_if.out_zero;

  // Reference: plain integer A+B+cin / A-B-borrow on w-bit unsigned and signed views.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t    e;
    longint  mask = (longint'(1) << w) - 1;
    longint  half = longint'(1) << (w - 1);
    longint  ua = longint'(a) & mask;
    longint  ub = longint'(b) & mask;
    longint  sa = (ua >= half) ? ua - 2 * half : ua;
    longint  sb = (ub >= half) ? ub - 2 * half : ub;
    longint  ci = longint'(cin);
    longint  r;
    longint  s;
    if (!sub) begin
      r = ua + ub + ci;
      s = sa + sb + ci;
      e.cout = (r >= 2 * half);
    end else begin
      r = ua - ub - ci;
      s = sa - sb - ci;
      e.cout = (r >= 0);
    end
    e.res  = 32'(r & mask);
    e.ovf  = (s >= half) || (s < -half);
    e.zero = ((r & mask) == 0);
    e.acc  = 0;
    e.stl  = 0;
    return e;
  endfunction

  exp_t q[NCH][$];
  int   stl[NCH];
  bit   seen[NCH];
  int   cyc = 0;

  initial for (int ch = 0; ch < NCH; ch++) begin stl[ch] = 0; seen[ch] = 1'b0; end

  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin q[ch].delete(); seen[ch] = 1'b0; end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (c_ird[ch] !== (!c_vld[ch] || c_ord[ch])) begin
          errors++;
          $display("FAIL in_ready ch%0d: got %b want %b", ch, c_ird[ch], !c_vld[ch] || c_ord[ch]);
        end
        if (c_vld[ch] === 1'b1) begin
          checks++;
          if (q[ch].size() == 0) begin
            errors++;
            $display("FAIL unexpected_out ch%0d: got valid result %h want no result", ch, c_res[ch]);
          end else begin
            e = q[ch][0];
            if ({c_res[ch], c_cout[ch], c_ovf[ch], c_zero[ch]} !== {e.res, e.cout, e.ovf, e.zero}) begin
              errors++;
              $display("FAIL result ch%0d: got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
                       ch, c_res[ch], c_cout[ch], c_ovf[ch], c_zero[ch], e.res, e.cout, e.ovf, e.zero);
            end
            if (!seen[ch]) begin
              checks++;
              if (cyc != e.acc + CS[ch] + stl[ch] - e.stl) begin
                errors++;
                $display("FAIL latency ch%0d: got %0d cycles want %0d", ch, cyc - e.acc,
                         CS[ch] + stl[ch] - e.stl);
              end
              seen[ch] = 1'b1;
            end
            if (c_ord[ch] === 1'b1) begin
              void'(q[ch].pop_front());
              seen[ch] = 1'b0;
            end
          end
        end
        if (m_if.in_valid && c_ird[ch] === 1'b1) begin
          n = model(CW[ch], m_if.in_a, m_if.in_b, m_if.in_cin, m_if.in_sub);
          n.acc = cyc;
          n.stl = stl[ch];
          q[ch].push_back(n);
        end
        if (c_ird[ch] !== 1'b1) stl[ch]++;
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Called half a cycle... no: called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n  = 0;
    bit ok = 1'b0;
    m_if.in_a = a;  m_if.in_b = b;  m_if.in_cin = cin;  m_if.in_sub = sub;
    m_if.in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = (m_if.in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    m_if.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no accept in %0d cycles want accept", n);
    end
  endtask

  task automatic wait_out(input string nm, input logic [31:0] res, input logic cout,
                          input logic ovf, input logic zero);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_if.out_valid !== 1'b1 && n < 20);
    if (m_if.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=%b want 1", nm, m_if.out_valid);
    end else begin
      chk({nm, "_res"}, m_if.adder_result, res);
      chk({nm, "_flags"}, {29'h0, m_if.out_cout, m_if.out_ovf, m_if.out_zero}, {29'h0, cout, ovf, zero});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time limit want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_if.in_valid  = 1'b0;
    m_if.in_a      = '0;
    m_if.in_b      = '0;
    m_if.in_cin    = 1'b0;
    m_if.in_sub    = 1'b0;
    m_if.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {31'h0, m_if.out_valid}, 32'h0);
    chk("reset_result", m_if.adder_result, 32'h0);
    chk("reset_flags", {29'h0, m_if.out_cout, m_if.out_ovf, m_if.out_zero}, 32'h0);
    chk("reset_in_ready", {31'h0, m_if.in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); wait_out("add_wrap",   32'h0000_0000, 1, 0, 1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1); wait_out("sub_ovf",    32'h7FFF_FFFF, 1, 1, 0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1); wait_out("sub_neg",    32'hFFFF_FFFE, 0, 0, 0);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); wait_out("add_cin_ov", 32'h8000_0000, 0, 1, 0);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0); wait_out("slice_cy",   32'h0001_0000, 0, 0, 0);
    send(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1); wait_out("sub_zero",   32'h0000_0000, 1, 0, 1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1); wait_out("sub_borrow", 32'hFFFF_FFFF, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (12) @(posedge clk);
    #1;

    m_if.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_in_ready", {31'h0, m_if.in_ready}, 32'h0);
        chk("stall_out_valid", {31'h0, m_if.out_valid}, 32'h1);
        m_if.out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;

    m_if.out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h0000_0003, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, m_if.out_valid}, 32'h0);
    chk("midrst_result", m_if.adder_result, 32'h0);
    chk("midrst_flags", {29'h0, m_if.out_cout, m_if.out_ovf, m_if.out_zero}, 32'h0);
    chk("midrst_in_ready", {31'h0, m_if.in_ready}, 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'h0, m_if.out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0); wait_out("post_rst_add", 32'h0000_0000, 1, 0, 1);

    repeat (12) @(posedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (q[ch].size() != 0) begin
        errors++;
        $display("FAIL drain ch%0d: got %0d pending results want 0", ch, q[ch].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
